uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- UART receiver for the SoC's serial input path; counterpart of the existing UART transmit path.
- Converts the asynchronous board UART_RX line into 8-bit bytes: 8N1 format, 16x oversampling, mid-bit sampling.
- Received bytes are buffered in a small first-word-fall-through FIFO.
- The read/valid interface and sticky error flags are consumed by the AHB-Lite UART peripheral.

Parameters:
- CLK_HZ, 50000000, HCLK frequency in Hz.
- BAUD, 19200, line rate in bit/s.
- FIFO_DEPTH, 8, number of byte entries; must be a power of 2, at least 2.

Ports:
- HCLK  input  1  system clock; all logic on rising edge.
- HRESET  input  1  asynchronous active-high reset.
- rx  input  1  raw serial line; idles high; asynchronous to HCLK.
- rd_en  input  1  pop the head byte this cycle. Ignored when rd_valid=0.
- rd_data  output  8  head byte of the FIFO. Valid only while rd_valid=1.
- rd_valid  output  1  FIFO not empty.
- frame_err  output  1  sticky: a stop bit was sampled low.
- overrun  output  1  sticky: a byte arrived while the FIFO was full and was dropped.
- clr_err  input  1  synchronous clear of frame_err and overrun.

Behaviour:
- Reset: all outputs go to 0; rd_data=8'h00; FIFO empty; FSM in IDLE; synchronizer flops set to 1 (idle level).
- Reset mid-frame aborts the frame; the partial byte is lost.
- Synchronizer: rx passes through 2 flops to give rx_s. All decisions use rx_s.
- Tick generator:
  - DIV = CLK_HZ/(BAUD*16), rounded to nearest, minimum 1.
  - Free-running counter emits a one-cycle tick every DIV HCLK cycles.
  - The counter restarts on the IDLE->START transition, aligning ticks to the start edge.
- Oversample counter os[3:0] advances on each tick. The sample point is os==7.
- FSM states and transitions:
  - IDLE: rx_s==0 -> START, with os=0.
  - START: at sample point, rx_s==1 -> IDLE (false start, no flag raised); rx_s==0 -> DATA.
  - DATA: 8 bits, LSB first. Each bit is sampled at os==7 of its bit period and shifted into a shift register. bit_cnt 0..7. After bit 7 -> STOP (or PARITY when the optional feature is enabled).
  - STOP: at sample point, rx_s==1 -> push byte; rx_s==0 -> frame_err<=1, byte discarded. Then -> IDLE immediately, which permits back-to-back frames with one stop bit.
- Push timing: the byte appears on rd_data and rd_valid rises 1 HCLK after the stop-bit sample cycle, if the FIFO was empty.
- FIFO (first-word fall-through):
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - full when pointer MSBs differ and the remaining bits are equal; empty when the pointers are equal.
  - Push while full with no pop: byte dropped, overrun<=1.
  - Push and pop in the same cycle while full: both accepted; no overrun.
  - Push and pop in the same cycle while empty: the pop is ignored and the push is accepted.
  - rd_en while empty: no effect.
- Error flags: clr_err clears both flags; if a set and a clear coincide in the same cycle, the set wins.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- With the macro defined:
  - A PARITY state is inserted between DATA and STOP.
  - An extra input odd_parity (1 bit) selects odd parity when 1, even when 0.
  - An extra sticky output parity_err is set when the sampled parity bit mismatches.
  - The byte is still pushed if the stop bit is good; clr_err also clears parity_err.
- Without the macro: there is no PARITY state, odd_parity or parity_err; the frame is 8N1.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP).
  - OS_RATE=16, OS_MID=7, DATA_BITS=8.
  - function calc_div(clk_hz, baud).
- Natural sub-module: byte_fifo (parameterised depth; FWFT; push/pop/full/empty). uart_rx_fifo instantiates it.

Test Plan:
- Bench config CLK_HZ=1600000, BAUD=100000, so DIV=1 and one bit = 16 HCLK. Scenario: send 8'hA5, 8N1 -> rd_data=8'hA5 and rd_valid=1 exactly 1 cycle after the stop-bit sample; frame_err=0.
- Drive a 5-HCLK low glitch on rx -> FSM returns to IDLE; rd_valid stays 0; no flags set.
- Send 8'h3C with the stop bit held low -> frame_err=1, FIFO stays empty. Then pulse clr_err -> frame_err=0.
- Send 9 bytes 8'h01..8'h09 with no reads, FIFO_DEPTH=8 -> overrun=1. Popping 8 times returns 01..08, then rd_valid=0.
- With FIFO full, hold rd_en=1 across the 9th byte's push cycle -> no overrun; the byte is stored; pops return 02..09.
- Assert HRESET mid-DATA while sending 8'h5A, then send 8'hC3 -> only 8'hC3 is received; all flags are 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and baud divider helper for the UART receiver
//
// Purpose : receiver FSM state encoding, oversampling constants and the
//           tick divider calculation used by uart_rx_fifo.
// Ports   : none (package).

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int         OS_RATE   = 16;
  localparam logic [3:0] OS_MID    = 4'd7;
  localparam int         DATA_BITS = 8;
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  // Oversample tick divider, rounded to nearest and never below 1.
  function automatic int calc_div(input int clk_hz, input int baud);
    int den;
    int q;
    den = baud * OS_RATE;
    q   = (clk_hz + den / 2) / den;
    return (q < 1) ? 1 : q;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - first-word-fall-through byte FIFO for received UART data
//
// Purpose : small FWFT buffer; the head entry is visible on data_o whenever
//           the FIFO is not empty.
// Ports   : clk_i      - clock, rising edge
//           rst_i      - asynchronous active-high reset
//           push_i     - write data_i this cycle
//           data_i     - write data
//           pop_i      - remove the head entry (ignored when empty)
//           data_o     - head entry, forced to zero while empty
//           empty_o    - FIFO holds no entries
//           overflow_o - push refused because the FIFO was full with no pop

module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the index bits match.
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full;
  logic             empty;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty;
  // A simultaneous pop frees the slot, so a full FIFO can still take the push.
  assign push_ok = push_i && (!full || pop_ok);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  assign data_o     = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign empty_o    = empty;
  assign overflow_o = push_i && full && !pop_ok;

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampling UART receiver with FWFT byte FIFO and sticky errors
//
// Purpose : receives 8N1 frames from an asynchronous rx line, sampling each
//           bit at the middle of its period, and buffers bytes in byte_fifo.
//           Optional parity support is enabled by defining UART_RX_PARITY_EN.
// Ports   : HCLK       - system clock, rising edge
//           HRESET     - asynchronous active-high reset
//           rx         - raw serial line, idles high
//           rd_en      - pop the head byte (ignored when rd_valid=0)
//           rd_data    - head byte, valid while rd_valid=1
//           rd_valid   - FIFO not empty
//           frame_err  - sticky, a stop bit was sampled low
//           overrun    - sticky, a byte was dropped because the FIFO was full
//           clr_err    - synchronous clear of the sticky flags
//           odd_parity - (UART_RX_PARITY_EN) 1 = odd parity, 0 = even
//           parity_err - (UART_RX_PARITY_EN) sticky, parity bit mismatch

module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 19200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  input  logic       odd_parity,
  output logic       parity_err,
`endif
  input  logic       clr_err
);

  localparam int             DIV      = calc_div(CLK_HZ, BAUD);
  localparam int             DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic             sync1_q;
  logic             rx_s;
  state_t           state_q, state_d;
  logic [3:0]       os_q, os_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             tick;
  logic             sample;
  logic             push;
  logic             frame_set;
  logic             fifo_empty;
  logic             fifo_overflow;
`ifdef UART_RX_PARITY_EN
  logic             parity_err_q, parity_err_d;
  logic             parity_set;
`endif

  // Two-flop synchronizer, preset to the idle line level.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s    <= sync1_q;
    end
  end

  assign tick   = (div_cnt_q == DIV_LAST);
  assign sample = tick && (os_q == OS_MID);

  always_comb begin
    state_d     = state_q;
    os_d        = os_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
    push        = 1'b0;
    frame_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_set  = 1'b0;
`endif
    if (tick) os_d = os_q + 4'd1;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          // Restart the divider so ticks line up with the start edge.
          state_d   = START;
          os_d      = 4'd0;
          div_cnt_d = '0;
          bit_cnt_d = 3'd0;
        end
      end
      START: begin
        if (sample) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (sample) begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample) begin
          // Even parity bit equals XOR of the data; odd parity inverts it.
          if (rx_s != ((^shift_q) ^ odd_parity)) parity_set = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (sample) begin
          if (rx_s) push = 1'b1;
          else      frame_set = 1'b1;
          // Leaving immediately lets a start bit follow a single stop bit.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Set has priority over clear.
    frame_err_d = frame_set     ? 1'b1 : (clr_err ? 1'b0 : frame_err_q);
    overrun_d   = fifo_overflow ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_set   ? 1'b1 : (clr_err ? 1'b0 : parity_err_q);
`endif
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= IDLE;
      os_q        <= 4'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      div_cnt_q   <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      os_q        <= os_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      div_cnt_q   <= div_cnt_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) parity_err_q <= 1'b0;
    else        parity_err_q <= parity_err_d;
  end
  assign parity_err = parity_err_q;
`endif

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk_i      (HCLK),
    .rst_i      (HRESET),
    .push_i     (push),
    .data_i     (shift_q),
    .pop_i      (rd_en),
    .data_o     (rd_data),
    .empty_o    (fifo_empty),
    .overflow_o (fifo_overflow)
  );

  assign rd_valid  = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo (one bit = 16 HCLK)

module tb_uart_rx_fifo;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic       rx;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       odd_parity;
  logic       parity_err;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 HCLK = ~HCLK;

  uart_rx_fifo #(
    .CLK_HZ     (1600000),
    .BAUD       (100000),
    .FIFO_DEPTH (8)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .rx         (rx),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .odd_parity (odd_parity),
    .parity_err (parity_err),
`endif
    .clr_err    (clr_err)
  );

  // Advance n rising edges and land 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // Full 8N1 frame from edge+1: stop sample cycle begins 154 edges in,
  // the push lands on edge 155; optionally pop during that sample cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic pop_at_stop);
    rx = 1'b0;
    step(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(16);
    end
    rx = stop_bit;
    step(10);
    rd_en = pop_at_stop;
    step(1);
    rd_en = 1'b0;
    step(5);
    rx = 1'b1;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    step(3);
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    tests_run++; if (rd_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun got %b want 0", overrun); end
    HRESET = 1'b0;
    step(5);
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL post_reset_rd_valid got %b want 0", rd_valid); end
  endtask

  task automatic test_single_byte();
    logic [7:0] b;
    b = 8'hA5;
    rx = 1'b0;
    step(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(16);
    end
    rx = 1'b1;
    step(10);
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL a5_early_valid got %b want 0", rd_valid); end
    step(1);
    tests_run++; if (rd_valid !== 1'b1) begin tests_failed++; $display("FAIL a5_valid got %b want 1", rd_valid); end
    tests_run++; if (rd_data !== 8'hA5) begin tests_failed++; $display("FAIL a5_data got %h want a5", rd_data); end
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL a5_frame_err got %b want 0", frame_err); end
    step(5);
    pop_one();
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL a5_after_pop_valid got %b want 0", rd_valid); end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    step(5);
    rx = 1'b1;
    step(30);
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL glitch_valid got %b want 0", rd_valid); end
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL glitch_frame_err got %b want 0", frame_err); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL glitch_overrun got %b want 0", overrun); end
    // A clean frame right after proves the receiver went back to idle.
    send_frame(8'h5C, 1'b1, 1'b0);
    step(2);
    tests_run++; if (rd_valid !== 1'b1) begin tests_failed++; $display("FAIL glitch_next_valid got %b want 1", rd_valid); end
    tests_run++; if (rd_data !== 8'h5C) begin tests_failed++; $display("FAIL glitch_next_data got %h want 5c", rd_data); end
    pop_one();
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 1'b0);
    step(20);
    tests_run++; if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL ferr_set got %b want 1", frame_err); end
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL ferr_valid got %b want 0", rd_valid); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL ferr_overrun got %b want 0", overrun); end
    pulse_clr();
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL ferr_clear got %b want 0", frame_err); end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0);
    step(2);
    tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_set got %b want 1", overrun); end
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL ovr_frame_err got %b want 0", frame_err); end
    for (int k = 1; k <= 8; k++) begin
      tests_run++; if (rd_valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_pop_valid[%0d] got %b want 1", k, rd_valid); end
      tests_run++; if (rd_data !== 8'(k)) begin tests_failed++; $display("FAIL ovr_pop_data[%0d] got %h want %h", k, rd_data, 8'(k)); end
      pop_one();
    end
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL ovr_drained got %b want 0", rd_valid); end
    pulse_clr();
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear got %b want 0", overrun); end
  endtask

  task automatic test_full_pop_push();
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1, 1'b0);
    send_frame(8'h09, 1'b1, 1'b1);
    step(2);
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL fpp_overrun got %b want 0", overrun); end
    for (int k = 2; k <= 9; k++) begin
      tests_run++; if (rd_valid !== 1'b1) begin tests_failed++; $display("FAIL fpp_pop_valid[%0d] got %b want 1", k, rd_valid); end
      tests_run++; if (rd_data !== 8'(k)) begin tests_failed++; $display("FAIL fpp_pop_data[%0d] got %h want %h", k, rd_data, 8'(k)); end
      pop_one();
    end
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL fpp_drained got %b want 0", rd_valid); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    // Leave a byte buffered and frame_err set so the reset has something to clear.
    send_frame(8'h77, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    step(20);
    b = 8'h5A;
    rx = 1'b0;
    step(16);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      step(16);
    end
    HRESET = 1'b1;
    rx = 1'b1;
    step(2);
    HRESET = 1'b0;
    step(20);
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_valid got %b want 0", rd_valid); end
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_frame_err got %b want 0", frame_err); end
    send_frame(8'hC3, 1'b1, 1'b0);
    step(2);
    tests_run++; if (rd_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_c3_valid got %b want 1", rd_valid); end
    tests_run++; if (rd_data !== 8'hC3) begin tests_failed++; $display("FAIL rst_c3_data got %h want c3", rd_data); end
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL rst_c3_frame_err got %b want 0", frame_err); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL rst_c3_overrun got %b want 0", overrun); end
    pop_one();
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_c3_drained got %b want 0", rd_valid); end
  endtask

  initial begin
    HRESET  = 1'b1;
    rx      = 1'b1;
    rd_en   = 1'b0;
    clr_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    odd_parity = 1'b0;
`endif
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_full_pop_push();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
